// File: rtl/m_ctrl_pkg.sv
// m_ctrl_pkg: shared constants for the multi-cycle MIPS control unit.
//   state_t   - FSM state encoding (value is exported on state_out)
//   ALU_*     - ALU_operation codes
//   OP_* / FN_* - instruction opcode [31:26] and R-type funct [5:0] values
package m_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF    = 5'd0,
        S_ID    = 5'd1,
        S_MADDR = 5'd2,
        S_MRD   = 5'd3,
        S_LWWB  = 5'd4,
        S_MWR   = 5'd5,
        S_REXE  = 5'd6,
        S_RWB   = 5'd7,
        S_BR    = 5'd8,
        S_J     = 5'd9,
        S_IEXE  = 5'd10,
        S_IWB   = 5'd11,
        S_JAL   = 5'd12,
        S_JR    = 5'd13
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/m_ctrl_alu_dec.sv
// m_ctrl_alu_dec: ALU operation select for the control FSM.
//   state  in  current FSM state
//   opcode in  Inst_in[31:26]
//   funct  in  Inst_in[5:0]
//   alu_op out ALU_operation code (000 in states that do not use the ALU)
import m_ctrl_pkg::*;

module m_ctrl_alu_dec (
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_AND;
        case (state)
            S_IF, S_ID, S_MADDR: alu_op = ALU_ADD;
            S_BR:                alu_op = ALU_SUB;
            S_REXE, S_RWB: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_IEXE, S_IWB: begin
                case (opcode)
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_XORI: alu_op = ALU_XOR;
                    default: alu_op = ALU_ADD;   // addi, lui
                endcase
            end
            default: alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/m_ctrl.sv
// m_ctrl: Moore control FSM of a multi-cycle MIPS datapath.
//   clk, reset (sync, active-high) ; Inst_in (IR), zero, overflow, MIO_ready
//   MemRead, MemWrite, CPU_MIO, IorD          memory interface controls
//   IRWrite, RegWrite, PCWrite, PCWriteCond   write enables
//   RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, Branch  datapath muxes
//   ALU_operation, state_out                  ALU op, current state code
// Optional: define MCTRL_OVF_TRAP_EN to suppress register write-back of
// add/sub/addi results that overflowed.
import m_ctrl_pkg::*;

module m_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  ALU_operation,
    output logic [4:0]  state_out,
    output logic        CPU_MIO,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        Branch
);

    state_t     state, next_state;
    logic [5:0] opcode, funct;
    logic       wb_en;

    assign opcode = Inst_in[31:26];
    assign funct  = Inst_in[5:0];

    // zero is consumed by the datapath together with PCWriteCond/Branch.
`ifdef MCTRL_OVF_TRAP_EN
    logic unused_bits;
    assign unused_bits = &{1'b0, Inst_in[25:6], zero};
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, Inst_in[25:6], zero, overflow};
`endif

    m_ctrl_alu_dec u_alu_dec (
        .state  (state),
        .opcode (opcode),
        .funct  (funct),
        .alu_op (ALU_operation)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IF;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF:    next_state = MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:   next_state = S_MADDR;
                    OP_RTYPE:       next_state = (funct == FN_JR) ? S_JR : S_REXE;
                    OP_BEQ, OP_BNE: next_state = S_BR;
                    OP_J:           next_state = S_J;
                    OP_JAL:         next_state = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:
                                    next_state = S_IEXE;
                    default:        next_state = S_IF;
                endcase
            end
            S_MADDR: next_state = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:   next_state = MIO_ready ? S_LWWB : S_MRD;
            S_MWR:   next_state = MIO_ready ? S_IF : S_MWR;
            S_REXE:  next_state = S_RWB;
            S_IEXE:  next_state = S_IWB;
            default: next_state = S_IF;
        endcase
    end

    // Write-back enable for RWB/IWB; overflowing add/sub/addi may be trapped.
    always_comb begin
        wb_en = 1'b1;
`ifdef MCTRL_OVF_TRAP_EN
        if (overflow) begin
            if (state == S_RWB && (funct == FN_ADD || funct == FN_SUB))
                wb_en = 1'b0;
            if (state == S_IWB && opcode == OP_ADDI)
                wb_en = 1'b0;
        end
`endif
    end

    assign state_out = state;

    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        CPU_MIO     = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        Branch      = 1'b0;
        case (state)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                IRWrite = MIO_ready;    // fetch completes only when memory is ready
                PCWrite = MIO_ready;
                ALUSrcB = 2'b01;
            end
            S_ID:    ALUSrcB = 2'b11;
            S_MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_LWWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                CPU_MIO  = 1'b1;
            end
            S_REXE:  ALUSrcA = 1'b1;
            S_RWB: begin
                ALUSrcA  = 1'b1;
                RegWrite = wb_en;
                RegDst   = 2'b01;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Branch      = ~opcode[0];
            end
            S_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                ALUSrcA  = 1'b1;
            end
            S_IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_IWB: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                RegWrite = wb_en;
                MemtoReg = (opcode == OP_LUI) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_m_ctrl.sv
// tb_m_ctrl: self-checking bench for m_ctrl. A reference model derived from
// each instruction's state path and the per-state output table is compared
// with the DUT every cycle; directed sequences pin the model with literals.
module tb_m_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, overflow, MIO_ready;
    logic [31:0] Inst_in;
    logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
    logic        PCWrite, PCWriteCond, ALUSrcA, Branch;
    logic [2:0]  ALU_operation;
    logic [4:0]  state_out;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;

    int n_checks = 0;
    int n_err    = 0;
    int cycle    = 0;
    bit chk_en   = 1'b0;

    m_ctrl dut (
        .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero),
        .overflow(overflow), .MIO_ready(MIO_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALU_operation(ALU_operation),
        .state_out(state_out), .CPU_MIO(CPU_MIO), .IorD(IorD),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .Branch(Branch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct packed {
        logic       mem_read, mem_write;
        logic [2:0] alu;
        logic       cpu_mio, iord, ir_write, reg_write, pc_write, pc_write_cond;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, pc_source;
        logic       branch;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {MemRead, MemWrite, ALU_operation, CPU_MIO, IorD, IRWrite,
                    RegWrite, PCWrite, PCWriteCond, RegDst, MemtoReg, ALUSrcA,
                    ALUSrcB, PCSource, Branch};

    // State visited at position idx of an instruction's walk (IF first), -1 past the end.
    function automatic int path_at(input logic [31:0] inst, input int idx);
        int p[6];
        int n;
        logic [5:0] op, fn;
        op = inst[31:26];
        fn = inst[5:0];
        foreach (p[k]) p[k] = 0;
        p[1] = 1;
        n = 2;
        case (op)
            6'h23: begin p[2] = 2; p[3] = 3; p[4] = 4; n = 5; end
            6'h2B: begin p[2] = 2; p[3] = 5; n = 4; end
            6'h00: if (fn == 6'h08) begin p[2] = 13; n = 3; end
                   else begin p[2] = 6; p[3] = 7; n = 4; end
            6'h04, 6'h05: begin p[2] = 8; n = 3; end
            6'h02: begin p[2] = 9; n = 3; end
            6'h03: begin p[2] = 12; n = 3; end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
                   begin p[2] = 10; p[3] = 11; n = 4; end
            default: n = 2;
        endcase
        return (idx < n) ? p[idx] : -1;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h26: return 3'b011;
            6'h27: return 3'b100;
            6'h2A: return 3'b111;
            6'h02: return 3'b101;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            6'h0A: return 3'b111;
            6'h0C: return 3'b000;
            6'h0D: return 3'b001;
            6'h0E: return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic outs_t expect_out(input int st, input logic [31:0] inst,
                                         input logic rdy, input logic ovf);
        outs_t o;
        logic [5:0] op, fn;
        logic trap;
        op = inst[31:26];
        fn = inst[5:0];
        o = '0;
        trap = 1'b0;
`ifdef MCTRL_OVF_TRAP_EN
        trap = ovf && ((st == 7 && (fn == 6'h20 || fn == 6'h22)) || (st == 11 && op == 6'h08));
`else
        trap = ovf & 1'b0;
`endif
        case (st)
            0:  begin o.mem_read = 1; o.cpu_mio = 1; o.ir_write = rdy; o.pc_write = rdy;
                      o.alu_src_b = 2'b01; o.alu = 3'b010; end
            1:  begin o.alu_src_b = 2'b11; o.alu = 3'b010; end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu = 3'b010; end
            3:  begin o.mem_read = 1; o.iord = 1; o.cpu_mio = 1; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
            5:  begin o.mem_write = 1; o.iord = 1; o.cpu_mio = 1; end
            6:  begin o.alu_src_a = 1; o.alu = r_alu(fn); end
            7:  begin o.alu_src_a = 1; o.alu = r_alu(fn); o.reg_write = !trap;
                      o.reg_dst = 2'b01; end
            8:  begin o.alu_src_a = 1; o.alu = 3'b110; o.pc_write_cond = 1;
                      o.pc_source = 2'b01; o.branch = ~op[0]; end
            9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
            10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu = i_alu(op); end
            11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu = i_alu(op);
                      o.reg_write = !trap; o.mem_to_reg = (op == 6'h0F) ? 2'b10 : 2'b00; end
            12: begin o.pc_write = 1; o.pc_source = 2'b10; o.reg_write = 1;
                      o.reg_dst = 2'b10; o.mem_to_reg = 2'b11; end
            13: begin o.pc_write = 1; o.pc_source = 2'b11; o.alu_src_a = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Reference model: position along the current instruction's path.
    int m_state = 0;
    int m_pos   = 0;

    always @(posedge clk) begin
        int nxt;
        if (reset) begin
            m_state <= 0;
            m_pos   <= 0;
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !MIO_ready) begin
            m_state <= m_state;
        end else begin
            nxt = path_at(Inst_in, m_pos + 1);
            if (nxt < 0) begin
                m_state <= 0;
                m_pos   <= 0;
            end else begin
                m_state <= nxt;
                m_pos   <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        outs_t e;
        if (chk_en) begin
            e = expect_out(m_state, Inst_in, MIO_ready, overflow);
            n_checks++;
            if (state_out !== m_state[4:0]) begin
                n_err++;
                $display("FAIL model_state cycle %0d: got %0d want %0d", cycle, state_out, m_state);
            end
            n_checks++;
            if (dut_o !== e) begin
                n_err++;
                $display("FAIL model_outputs cycle %0d state %0d inst %h: got %h want %h",
                         cycle, m_state, Inst_in, dut_o, e);
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc(input logic r, input logic [31:0] i, input logic rdy,
                       input logic z, input logic o);
        @(posedge clk);
        #1;
        reset = r; Inst_in = i; MIO_ready = rdy; zero = z; overflow = o;
        @(negedge clk);
    endtask

    task automatic step(input string nm, input logic [31:0] i, input logic rdy,
                        input logic z, input logic r, input int want);
        cyc(r, i, rdy, z, 1'b0);
        check_lit(nm, state_out, want);
    endtask

    function automatic bit known_op(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] v;
        logic [5:0] op;
        logic [5:0] fns [10];
        logic [5:0] iops [6];
        fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h08, 6'h3F};
        iops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[31:26] = 6'h23;
            1: v[31:26] = 6'h2B;
            2: begin v[31:26] = 6'h00; v[5:0] = fns[$urandom_range(0, 9)]; end
            3: v[31:26] = 6'h04;
            4: v[31:26] = 6'h05;
            5: v[31:26] = 6'h02;
            6: v[31:26] = 6'h03;
            7: v[31:26] = iops[$urandom_range(0, 5)];
            8: begin
                op = 6'($urandom_range(0, 63));
                while (known_op(op)) op = 6'($urandom_range(0, 63));
                v[31:26] = op;
            end
            default: v[31:26] = 6'h00;
        endcase
        return v;
    endfunction

    localparam logic [31:0] LW   = 32'h8E520000;
    localparam logic [31:0] SW   = 32'hAE520000;
    localparam logic [31:0] RADD = 32'h02538820;
    localparam logic [31:0] RSUB = 32'h02538822;
    localparam logic [31:0] BEQ  = 32'h12520004;
    localparam logic [31:0] BNE  = 32'h16520004;
    localparam logic [31:0] JAL  = 32'h0C000000;
    localparam logic [31:0] UNK  = 32'hFC000000;

    initial begin
        reset = 1'b1; Inst_in = '0; MIO_ready = 1'b1; zero = 1'b0; overflow = 1'b0;
        cyc(1'b1, '0, 1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, '0, 1'b1, 1'b0, 1'b0);
        check_lit("reset_state", state_out, 0);

        step("lw_if", LW, 1, 0, 0, 0);
        check_lit("if_memread", MemRead, 1);
        check_lit("if_pcwrite", PCWrite, 1);
        check_lit("if_alusrcb", ALUSrcB, 1);
        step("lw_id", LW, 1, 0, 0, 1);
        check_lit("id_alusrcb", ALUSrcB, 3);
        step("lw_maddr", LW, 1, 0, 0, 2);
        step("lw_mrd", LW, 1, 0, 0, 3);
        step("lw_lwwb", LW, 1, 0, 0, 4);
        check_lit("lwwb_regwrite", RegWrite, 1);
        check_lit("lwwb_memtoreg", MemtoReg, 1);

        step("add_if", RADD, 1, 0, 0, 0);
        step("add_id", RADD, 1, 0, 0, 1);
        step("add_rexe", RADD, 1, 0, 0, 6);
        check_lit("add_aluop", ALU_operation, 2);
        step("add_rwb", RADD, 1, 0, 0, 7);
        check_lit("rwb_regdst", RegDst, 1);
        check_lit("rwb_regwrite", RegWrite, 1);

        step("sub_if", RSUB, 1, 0, 0, 0);
        step("sub_id", RSUB, 1, 0, 0, 1);
        step("sub_rexe", RSUB, 1, 0, 0, 6);
        check_lit("sub_aluop", ALU_operation, 6);
        step("sub_rwb", RSUB, 1, 0, 0, 7);

        step("beq_if", BEQ, 1, 1, 0, 0);
        step("beq_id", BEQ, 1, 1, 0, 1);
        step("beq_br", BEQ, 1, 1, 0, 8);
        check_lit("beq_pcwc", PCWriteCond, 1);
        check_lit("beq_branch", Branch, 1);
        check_lit("beq_pcsrc", PCSource, 1);
        step("bne_if", BNE, 1, 0, 0, 0);
        step("bne_id", BNE, 1, 0, 0, 1);
        step("bne_br", BNE, 1, 0, 0, 8);
        check_lit("bne_branch", Branch, 0);

        step("jal_if", JAL, 1, 0, 0, 0);
        step("jal_id", JAL, 1, 0, 0, 1);
        step("jal_jal", JAL, 1, 0, 0, 12);
        check_lit("jal_regdst", RegDst, 2);
        check_lit("jal_memtoreg", MemtoReg, 3);
        check_lit("jal_pcsrc", PCSource, 2);
        check_lit("jal_pcwrite", PCWrite, 1);

        step("stall_if", LW, 0, 0, 0, 0);
        check_lit("stall_irwrite", IRWrite, 0);
        check_lit("stall_pcwrite", PCWrite, 0);
        step("stall_if_rel", LW, 1, 0, 0, 0);
        check_lit("rel_irwrite", IRWrite, 1);
        step("stall_id", LW, 1, 0, 0, 1);
        step("stall_maddr", LW, 1, 0, 0, 2);
        step("stall_mrd", LW, 0, 0, 0, 3);
        step("stall_mrd_hold", LW, 1, 0, 0, 3);
        step("stall_lwwb", LW, 1, 0, 0, 4);

        step("sw_if", SW, 1, 0, 0, 0);
        step("sw_id", SW, 1, 0, 0, 1);
        step("sw_maddr", SW, 1, 0, 0, 2);
        step("sw_mwr", SW, 1, 0, 0, 5);
        check_lit("mwr_memwrite", MemWrite, 1);

        step("rst_if", RADD, 1, 0, 0, 0);
        step("rst_id", RADD, 1, 0, 0, 1);
        step("rst_rexe", RADD, 1, 0, 1, 6);
        step("unk_if", UNK, 1, 0, 0, 0);
        step("unk_id", UNK, 1, 0, 0, 1);
        step("unk_back", UNK, 1, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (m_state == 0) Inst_in = gen_inst();
            MIO_ready = ($urandom_range(0, 3) != 0);
            zero      = 1'($urandom_range(0, 1));
            overflow  = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
